pipe_reg_chain: RTL and testbench

//  Parametrised successor of the 8-bit D flip-flop: a WIDTH-bit, DEPTH-stage elastic register pipeline.

---
 rtl/pipe_reg_chain_pkg.sv | 19 +
 rtl/pipe_reg_stage.sv | 49 ++++
 rtl/pipe_reg_chain.sv | 114 +++++++++++
 tb/tb_pipe_reg_chain.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipe_reg_chain elastic register pipeline.
//   DEF_WIDTH / DEF_DEPTH : default beat width and stage count
//   occ_w(depth)          : width of an occupancy count able to hold 0..depth
//   stage_t               : one stage's {valid, data} pair at the default width
package pipe_reg_chain_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 v;
    logic [DEF_WIDTH-1:0] d;
  } stage_t;

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-low reset (clears valid and data)
//   i_clr    synchronous invalidate (flush); data is left untouched
//   i_rdy    this stage may take the upstream beat/bubble this cycle
//   i_valid  upstream valid
//   i_data   upstream data
//   o_valid  stage valid
//   o_data   stage data
module pipe_reg_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_rdy,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else begin
      if (i_clr) begin
        r_v <= 1'b0;
      end else if (i_rdy) begin
        r_v <= i_valid;
      end
      // Data only moves with a real beat, so bubbles never toggle the register.
      if (i_rdy && i_valid && !i_clr) begin
        r_d <= i_data;
      end
    end
  end

  assign o_valid = r_v;
  assign o_data  = r_d;

endmodule

// File: rtl/pipe_reg_chain.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with a bubble-collapsing
// ready chain. Zero-stall latency is DEPTH cycles; order is preserved.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high; valid never depends on ready, while in_ready is a
// combinational function of the stage valids, out_ready, flush and reset.
//
// Optional feature (macro PIPE_REG_CHAIN_OCC_EN): adds o_occupancy, a
// registered count of held beats. Without the macro the port is absent.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      asynchronous active-low reset
//   i_flush      synchronous invalidate of every stage
//   i_in_valid   producer beat present
//   o_in_ready   stage 0 can accept this cycle
//   i_in_data    producer payload
//   o_out_valid  last stage holds a beat
//   i_out_ready  consumer accepts this cycle
//   o_out_data   last-stage payload
//   o_occupancy  beats held (only with PIPE_REG_CHAIN_OCC_EN)
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [WIDTH-1:0]          i_in_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [WIDTH-1:0]          o_out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0]   o_occupancy
`endif
);

  logic             w_v   [DEPTH];
  logic [WIDTH-1:0] w_d   [DEPTH];
  logic             w_rdy [DEPTH];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             w_vin;
    logic [WIDTH-1:0] w_din;

    if (gi == 0) begin : g_head
      // A flushing cycle injects a bubble rather than the offered beat.
      assign w_vin = i_in_valid && !i_flush;
      assign w_din = i_in_data;
    end else begin : g_body
      assign w_vin = w_v[gi-1];
      assign w_din = w_d[gi-1];
    end

    // An empty stage is always ready, which is what collapses bubbles.
    if (gi == DEPTH - 1) begin : g_tail_rdy
      assign w_rdy[gi] = !w_v[gi] || i_out_ready;
    end else begin : g_mid_rdy
      assign w_rdy[gi] = !w_v[gi] || w_rdy[gi+1];
    end

    pipe_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clr   (i_flush),
      .i_rdy   (w_rdy[gi]),
      .i_valid (w_vin),
      .i_data  (w_din),
      .o_valid (w_v[gi]),
      .o_data  (w_d[gi])
    );
  end

  assign o_in_ready  = w_rdy[0] && !i_flush && i_reset;
  assign o_out_valid = w_v[DEPTH-1];
  assign o_out_data  = w_d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = occ_w(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic             w_acc_in;
  logic             w_acc_out;
  logic [OCC_W-1:0] r_occ;

  assign w_acc_in  = i_in_valid && o_in_ready;
  assign w_acc_out = o_out_valid && i_out_ready;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_occ <= '0;
    end else if (i_flush) begin
      r_occ <= '0;
    end else begin
      case ({w_acc_in, w_acc_out})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, DEPTH=4). Occupancy checks are
// compiled in when PIPE_REG_CHAIN_OCC_EN is defined.
module tb_pipe_reg_chain;
  import pipe_reg_chain_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [occ_w(DEPTH)-1:0] occ;
`endif

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .o_occupancy (occ)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] drv_q[$];
  logic [WIDTH-1:0] acc_q[$];
  logic [WIDTH-1:0] got_q[$];
  int               acc_cyc_q[$];
  int               got_cyc_q[$];

  // Passive observer: logs every handshake at the negative edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) begin
        acc_q.push_back(in_data);
        acc_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  // Offer drv_q beats back-to-back, popping each one when accepted.
  task automatic drive_all(input int budget);
    int b;
    b = budget;
    while (drv_q.size() > 0 && b > 0) begin
      in_valid = 1'b1;
      in_data  = drv_q[0];
      @(negedge clk);
      if (in_ready) void'(drv_q.pop_front());
      tick();
      b--;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    stage_t obs;
    clear_logs();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1; flush = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    obs.v = out_valid;
    obs.d = out_data;
    n_tests++; if (obs.v !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", obs.v); end
    n_tests++; if (obs.d !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %02h expected 00", obs.d); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    n_tests++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL reset_no_accept: got %0d accepts expected 0", acc_q.size()); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    n_tests++; if (occ !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
`endif
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] v;
    int lat, span_in, span_out;
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      v = WIDTH'($urandom_range(0, 255));
      exp_q.push_back(v);
      drv_q.push_back(v);
    end
    drive_all(60);
    wait_out(40, 20);
    n_tests++; if (acc_q.size() != 40) begin n_fail++; $display("FAIL stream_accepts: got %0d expected 40", acc_q.size()); end
    n_tests++; if (got_q.size() != 40) begin n_fail++; $display("FAIL stream_outputs: got %0d expected 40", got_q.size()); end
    lat      = (acc_cyc_q.size() > 0 && got_cyc_q.size() > 0) ? got_cyc_q[0] - acc_cyc_q[0] : -1;
    span_in  = (acc_cyc_q.size() == 40) ? acc_cyc_q[39] - acc_cyc_q[0] : -1;
    span_out = (got_cyc_q.size() == 40) ? got_cyc_q[39] - got_cyc_q[0] : -1;
    n_tests++; if (lat != DEPTH) begin n_fail++; $display("FAIL stream_latency: got %0d expected %0d", lat, DEPTH); end
    n_tests++; if (span_in != 39) begin n_fail++; $display("FAIL stream_in_rate: got span %0d expected 39", span_in); end
    n_tests++; if (span_out != 39) begin n_fail++; $display("FAIL stream_out_rate: got span %0d expected 39", span_out); end
    for (int k = 0; k < 40 && k < got_q.size(); k++) begin
      n_tests++;
      if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stream_data[%0d]: got %02h expected %02h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    int span;
    clear_logs();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(WIDTH'(8'h30 + k));
      drv_q.push_back(WIDTH'(8'h30 + k));
    end
    drive_all(8);
    @(negedge clk);
    n_tests++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", acc_q.size()); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %0b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h30) begin n_fail++; $display("FAIL bp_head: got v=%0b d=%02h expected v=1 d=30", out_valid, out_data); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    n_tests++; if (occ !== 3'd4) begin n_fail++; $display("FAIL bp_occ: got %0d expected 4", occ); end
`endif
    tick();
    out_ready = 1'b1;
    drive_all(10);
    wait_out(6, 20);
    n_tests++; if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_outputs: got %0d expected 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      n_tests++;
      if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_data[%0d]: got %02h expected %02h", k, got_q[k], exp_q[k]); end
    end
    span = (got_cyc_q.size() == 6) ? got_cyc_q[5] - got_cyc_q[0] : -1;
    n_tests++; if (span != 5) begin n_fail++; $display("FAIL bp_no_gaps: got span %0d expected 5", span); end
  endtask

  task automatic test_bubble();
    int span;
    clear_logs();
    out_ready = 1'b0;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    drv_q.push_back(8'h11);
    drive_all(2);
    repeat (2) tick();
    drv_q.push_back(8'h22);
    drive_all(2);
    repeat (4) tick();
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL bubble_head: got v=%0b d=%02h expected v=1 d=11", out_valid, out_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_in_ready_2: got %0b expected 1", in_ready); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    n_tests++; if (occ !== 3'd2) begin n_fail++; $display("FAIL bubble_occ2: got %0d expected 2", occ); end
`endif
    tick();
    drv_q.push_back(8'h33); drv_q.push_back(8'h44);
    drive_all(2);
    n_tests++; if (drv_q.size() != 0) begin n_fail++; $display("FAIL bubble_fill: got %0d beats refused expected 0", drv_q.size()); end
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bubble_in_ready_4: got %0b expected 0", in_ready); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    n_tests++; if (occ !== 3'd4) begin n_fail++; $display("FAIL bubble_occ4: got %0d expected 4", occ); end
`endif
    tick();
    out_ready = 1'b1;
    wait_out(4, 20);
    n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bubble_outputs: got %0d expected 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      n_tests++;
      if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bubble_data[%0d]: got %02h expected %02h", k, got_q[k], exp_q[k]); end
    end
    span = (got_cyc_q.size() == 4) ? got_cyc_q[3] - got_cyc_q[0] : -1;
    n_tests++; if (span != 3) begin n_fail++; $display("FAIL bubble_adjacent: got span %0d expected 3", span); end
  endtask

  task automatic test_flush();
    clear_logs();
    out_ready = 1'b1;
    drv_q.push_back(8'hA1); drv_q.push_back(8'hA2); drv_q.push_back(8'hA3);
    drive_all(5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    n_tests++; if (occ !== '0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occ); end
`endif
    repeat (8) tick();
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_emitted: got %0d beats expected 0", got_q.size()); end
    n_tests++; if (acc_q.size() != 3) begin n_fail++; $display("FAIL flush_accepts: got %0d expected 3", acc_q.size()); end
  endtask

  task automatic test_async_reset();
    int lat;
    clear_logs();
    out_ready = 1'b0;
    drv_q.push_back(8'hC1); drv_q.push_back(8'hC2); drv_q.push_back(8'hC3); drv_q.push_back(8'hC4);
    drive_all(6);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_full: got %0b expected 1", out_valid); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %0b expected 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_in_ready: got %0b expected 0", in_ready); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL areset_out_data: got %02h expected 00", out_data); end
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    clear_logs();
    drv_q.push_back(8'h5A);
    drive_all(2);
    wait_out(1, 12);
    repeat (6) tick();
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL areset_outputs: got %0d expected 1", got_q.size()); end
    n_tests++; if (got_q.size() < 1 || got_q[0] !== 8'h5A) begin n_fail++; $display("FAIL areset_data: got %02h expected 5a", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    lat = (acc_cyc_q.size() > 0 && got_cyc_q.size() > 0) ? got_cyc_q[0] - acc_cyc_q[0] : -1;
    n_tests++; if (lat != DEPTH) begin n_fail++; $display("FAIL areset_latency: got %0d expected %0d", lat, DEPTH); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
